// File: rtl/gol_engine.sv
`default_nettype none
// ============================================================================
//  Module   : gol_engine
//  Purpose  : Conway's Game of Life engine (rule B3/S23) on a WIDTH x HEIGHT
//             register grid. Generations are evolved row-serially, one row per
//             clock, updating the grid in place. Supports cursor editing while
//             idle, run mode driven by rate ticks, single stepping, and a
//             per-generation choice of toroidal or dead-border edges.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n            clock, asynchronous active-low reset
//    run_toggle_i          pulse: flip run mode
//    step_i                pulse: evolve one generation while paused
//    clear_i               pulse: kill all cells, zero generation count
//    tick_i                pulse: start a generation while running
//    wrap_i                edge mode (1 toroidal / 0 dead), sampled at start
//    move_*_i              cursor move pulses (wrapping)
//    toggle_i              pulse: invert cell under the cursor (idle only)
//    grid_o                cell (x,y) at bit y*WIDTH+x
//    generation_o          completed generations (saturating)
//    sel_x_o, sel_y_o      cursor position
//    sel_alive_o           state of the cell under the cursor
//    running_o, busy_o     run mode / evolution in progress
//    gen_done_o            one-cycle pulse when a generation commits
//    stable_o, extinct_o   last generation changed nothing / left grid empty
// ============================================================================
module gol_engine #(
   parameter int WIDTH  = 16,
   parameter int HEIGHT = 16,
   parameter int GEN_W  = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        run_toggle_i,
   input  logic                        step_i,
   input  logic                        clear_i,
   input  logic                        tick_i,
   input  logic                        wrap_i,
   input  logic                        move_left_i,
   input  logic                        move_right_i,
   input  logic                        move_up_i,
   input  logic                        move_down_i,
   input  logic                        toggle_i,
   output logic [WIDTH*HEIGHT-1:0]     grid_o,
   output logic [GEN_W-1:0]            generation_o,
   output logic [$clog2(WIDTH)-1:0]    sel_x_o,
   output logic [$clog2(HEIGHT)-1:0]   sel_y_o,
   output logic                        sel_alive_o,
   output logic                        running_o,
   output logic                        busy_o,
   output logic                        gen_done_o,
   output logic                        stable_o,
   output logic                        extinct_o
);

   localparam int XW = $clog2(WIDTH);
   localparam int YW = $clog2(HEIGHT);
   localparam logic [XW-1:0]    C_LAST_X  = XW'(WIDTH - 1);
   localparam logic [YW-1:0]    C_LAST_Y  = YW'(HEIGHT - 1);
   localparam logic [GEN_W-1:0] C_GEN_MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EVOLVE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t            state_q;
   logic [WIDTH-1:0]  rows_q [HEIGHT];
   logic [WIDTH-1:0]  prev_row_q;   // original (pre-update) copy of row r-1
   logic [WIDTH-1:0]  row0_q;       // original row 0, wrap neighbour of last row
   logic [YW-1:0]     row_q;
   logic              wrap_q;
   logic              changed_q;    // some row differed so far this generation
   logic              alive_q;      // some written row had a live cell so far
   logic [GEN_W-1:0]  gen_q;
   logic [XW-1:0]     sel_x_q;
   logic [YW-1:0]     sel_y_q;
   logic              running_q;
   logic              busy_q;
   logic              gen_done_q;
   logic              stable_q;
   logic              extinct_q;

   // -------------------------------------------------------------------------
   // Neighbour rows for the row being evolved. Rows above r have already been
   // overwritten, so the old row r-1 comes from prev_row_q and the old row 0
   // (needed by the last row under wrap) from row0_q. Row HEIGHT-1 is still
   // untouched while row 0 is processed, so it can be read from the grid.
   // -------------------------------------------------------------------------
   logic [YW-1:0]    w_row_dn;
   logic [WIDTH-1:0] w_cur;
   logic [WIDTH-1:0] w_above;
   logic [WIDTH-1:0] w_below;
   logic [WIDTH-1:0] w_row_next;

   assign w_row_dn = (row_q == C_LAST_Y) ? '0 : row_q + 1'b1;
   assign w_cur    = rows_q[row_q];
   assign w_above  = (row_q == '0) ? (wrap_q ? rows_q[HEIGHT-1] : '0) : prev_row_q;
   assign w_below  = (row_q == C_LAST_Y) ? (wrap_q ? row0_q : '0) : rows_q[w_row_dn];

   for (genvar x = 0; x < WIDTH; x++) begin : g_col
      localparam int XL = (x == 0) ? WIDTH - 1 : x - 1;
      localparam int XR = (x == WIDTH - 1) ? 0 : x + 1;
      localparam bit EDGE_L = (x == 0);
      localparam bit EDGE_R = (x == WIDTH - 1);

      logic       w_en_l;
      logic       w_en_r;
      logic [7:0] w_nb;
      logic [3:0] w_cnt;

      // Wrapped column neighbours are masked off in dead-border mode.
      assign w_en_l = wrap_q | ~EDGE_L;
      assign w_en_r = wrap_q | ~EDGE_R;
      assign w_nb   = {w_above[XL] & w_en_l, w_above[x], w_above[XR] & w_en_r,
                       w_cur[XL]   & w_en_l,             w_cur[XR]   & w_en_r,
                       w_below[XL] & w_en_l, w_below[x], w_below[XR] & w_en_r};

      always_comb begin
         w_cnt = '0;
         for (int k = 0; k < 8; k++) begin
            w_cnt = w_cnt + {3'b000, w_nb[k]};
         end
      end

      assign w_row_next[x] = (w_cnt == 4'd3) | (w_cur[x] & (w_cnt == 4'd2));
   end

   for (genvar y = 0; y < HEIGHT; y++) begin : g_row
      assign grid_o[y*WIDTH +: WIDTH] = rows_q[y];
   end

   // -------------------------------------------------------------------------
   // Control
   // -------------------------------------------------------------------------
   logic w_start;
   logic w_row_diff;
   logic w_go_l, w_go_r, w_go_u, w_go_d;

   assign w_start    = (step_i & ~running_q) | (tick_i & running_q);
   assign w_row_diff = (w_row_next != w_cur);
   assign w_go_l     = move_left_i  & ~move_right_i;
   assign w_go_r     = move_right_i & ~move_left_i;
   assign w_go_u     = move_up_i    & ~move_down_i;
   assign w_go_d     = move_down_i  & ~move_up_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         for (int y = 0; y < HEIGHT; y++) rows_q[y] <= '0;
         prev_row_q <= '0;
         row0_q     <= '0;
         row_q      <= '0;
         wrap_q     <= 1'b0;
         changed_q  <= 1'b0;
         alive_q    <= 1'b0;
         gen_q      <= '0;
         sel_x_q    <= '0;
         sel_y_q    <= '0;
         running_q  <= 1'b0;
         busy_q     <= 1'b0;
         gen_done_q <= 1'b0;
         stable_q   <= 1'b0;
         extinct_q  <= 1'b0;
      end else begin
         running_q  <= running_q ^ run_toggle_i;
         gen_done_q <= 1'b0;

         if (w_go_l)      sel_x_q <= (sel_x_q == '0) ? C_LAST_X : sel_x_q - 1'b1;
         else if (w_go_r) sel_x_q <= (sel_x_q == C_LAST_X) ? '0 : sel_x_q + 1'b1;
         if (w_go_u)      sel_y_q <= (sel_y_q == '0) ? C_LAST_Y : sel_y_q - 1'b1;
         else if (w_go_d) sel_y_q <= (sel_y_q == C_LAST_Y) ? '0 : sel_y_q + 1'b1;

         if (clear_i) begin
            // Clear wins in every state and aborts any generation in flight.
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            for (int y = 0; y < HEIGHT; y++) rows_q[y] <= '0;
            gen_q     <= '0;
            stable_q  <= 1'b0;
            extinct_q <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (w_start) begin
                     state_q   <= ST_EVOLVE;
                     busy_q    <= 1'b1;
                     row_q     <= '0;
                     wrap_q    <= wrap_i;
                     row0_q    <= rows_q[0];
                     changed_q <= 1'b0;
                     alive_q   <= 1'b0;
                  end else if (toggle_i) begin
                     rows_q[sel_y_q][sel_x_q] <= ~rows_q[sel_y_q][sel_x_q];
                  end
               end

               ST_EVOLVE: begin
                  rows_q[row_q] <= w_row_next;
                  prev_row_q    <= w_cur;
                  changed_q     <= changed_q | w_row_diff;
                  alive_q       <= alive_q | (|w_row_next);
                  if (row_q == C_LAST_Y) begin
                     // Commit: status reflects the full new generation.
                     state_q    <= ST_DONE;
                     gen_done_q <= 1'b1;
                     gen_q      <= (gen_q == C_GEN_MAX) ? gen_q : gen_q + 1'b1;
                     stable_q   <= ~(changed_q | w_row_diff);
                     extinct_q  <= ~(alive_q | (|w_row_next));
                  end else begin
                     row_q <= row_q + 1'b1;
                  end
               end

               ST_DONE: begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end

               default: begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign generation_o = gen_q;
   assign sel_x_o      = sel_x_q;
   assign sel_y_o      = sel_y_q;
   assign sel_alive_o  = rows_q[sel_y_q][sel_x_q];
   assign running_o    = running_q;
   assign busy_o       = busy_q;
   assign gen_done_o   = gen_done_q;
   assign stable_o     = stable_q;
   assign extinct_o    = extinct_q;

endmodule
`default_nettype wire

// File: tb/tb_gol_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gol_engine
//  Purpose  : Directed self-checking bench for gol_engine. Instance 0 is a
//             5x5 engine, instance 1 an 8x8 engine; both share clock and
//             reset but have independent control inputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gol_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [1:0] run_t, step, clr, tick, wrap, ml, mr, mu, md, tog;

   logic [24:0] grid5;
   logic [15:0] gen5;
   logic [2:0]  sx5, sy5;
   logic        alive5, run5, busy5, gd5, st5, ex5;

   logic [63:0] grid8;
   logic [15:0] gen8;
   logic [2:0]  sx8, sy8;
   logic        alive8, run8, busy8, gd8, st8, ex8;

   gol_engine #(.WIDTH(5), .HEIGHT(5), .GEN_W(16)) u_dut5 (
      .clk(clk), .rst_n(rst_n),
      .run_toggle_i(run_t[0]), .step_i(step[0]), .clear_i(clr[0]), .tick_i(tick[0]),
      .wrap_i(wrap[0]), .move_left_i(ml[0]), .move_right_i(mr[0]),
      .move_up_i(mu[0]), .move_down_i(md[0]), .toggle_i(tog[0]),
      .grid_o(grid5), .generation_o(gen5), .sel_x_o(sx5), .sel_y_o(sy5),
      .sel_alive_o(alive5), .running_o(run5), .busy_o(busy5),
      .gen_done_o(gd5), .stable_o(st5), .extinct_o(ex5)
   );

   gol_engine #(.WIDTH(8), .HEIGHT(8), .GEN_W(16)) u_dut8 (
      .clk(clk), .rst_n(rst_n),
      .run_toggle_i(run_t[1]), .step_i(step[1]), .clear_i(clr[1]), .tick_i(tick[1]),
      .wrap_i(wrap[1]), .move_left_i(ml[1]), .move_right_i(mr[1]),
      .move_up_i(mu[1]), .move_down_i(md[1]), .toggle_i(tog[1]),
      .grid_o(grid8), .generation_o(gen8), .sel_x_o(sx8), .sel_y_o(sy8),
      .sel_alive_o(alive8), .running_o(run8), .busy_o(busy8),
      .gen_done_o(gd8), .stable_o(st8), .extinct_o(ex8)
   );

   // gen_done pulses seen per instance, sampled on the inactive edge
   int gd_cnt [2] = '{0, 0};
   always @(negedge clk) begin
      if (gd5) gd_cnt[0]++;
      if (gd8) gd_cnt[1]++;
   end

   int checks = 0;
   int errors = 0;
   int cx [2] = '{0, 0};
   int cy [2] = '{0, 0};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] f_grid(input int d);
      return (d != 0) ? grid8 : {39'd0, grid5};
   endfunction
   function automatic logic f_busy(input int d);
      return (d != 0) ? busy8 : busy5;
   endfunction
   function automatic logic f_gd(input int d);
      return (d != 0) ? gd8 : gd5;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Walk the cursor to (x,y) with right/down moves, then invert that cell.
   task automatic set_cell(input int d, input int x, input int y);
      int n;
      n = (d != 0) ? 8 : 5;
      while (cx[d] != x) begin
         mr[d] = 1'b1; cyc(); mr[d] = 1'b0;
         cx[d] = (cx[d] + 1) % n;
      end
      while (cy[d] != y) begin
         md[d] = 1'b1; cyc(); md[d] = 1'b0;
         cy[d] = (cy[d] + 1) % n;
      end
      tog[d] = 1'b1; cyc(); tog[d] = 1'b0;
   endtask

   task automatic clear_grid(input int d);
      clr[d] = 1'b1; cyc(); clr[d] = 1'b0;
   endtask

   // Single step; k counts cycles after the start edge (k=1 is first busy cycle).
   task automatic gen_step(input int d, input int tog_at, input bit flip_wrap,
                           output int busy_cnt, output int done_at);
      int h;
      h = (d != 0) ? 8 : 5;
      step[d] = 1'b1; cyc(); step[d] = 1'b0;
      if (flip_wrap) wrap[d] = ~wrap[d];
      busy_cnt = 0;
      done_at  = 0;
      for (int k = 1; k <= h + 6; k++) begin
         if (f_busy(d)) busy_cnt++;
         if (f_gd(d) && done_at == 0) done_at = k;
         tog[d] = (k == tog_at);
         cyc();
      end
      tog[d] = 1'b0;
   endtask

   initial begin
      int bc, dn, g0;
      rst_n = 1'b0;
      run_t = '0; step = '0; clr = '0; tick = '0; wrap = '0;
      ml = '0; mr = '0; mu = '0; md = '0; tog = '0;
      cyc(); cyc();

      // ---------------- reset state ----------------
      chk("rst_grid5",  f_grid(0), 64'd0);
      chk("rst_gen5",   {48'd0, gen5}, 64'd0);
      chk("rst_sel5",   {58'd0, sx5, sy5}, 64'd0);
      chk("rst_flags5", {58'd0, alive5, run5, busy5, gd5, st5, ex5}, 64'd0);
      chk("rst_grid8",  f_grid(1), 64'd0);
      rst_n = 1'b1;
      cyc();

      // ---------------- cursor ----------------
      ml[0] = 1'b1; cyc(); ml[0] = 1'b0;
      chk("cur_left_wrap", {61'd0, sx5}, 64'd4);
      mu[0] = 1'b1; cyc(); mu[0] = 1'b0;
      chk("cur_up_wrap", {61'd0, sy5}, 64'd4);
      ml[0] = 1'b1; mr[0] = 1'b1; cyc(); ml[0] = 1'b0; mr[0] = 1'b0;
      chk("cur_cancel", {58'd0, sx5, sy5}, {58'd0, 3'd4, 3'd4});
      mr[0] = 1'b1; md[0] = 1'b1; cyc(); mr[0] = 1'b0; md[0] = 1'b0;
      chk("cur_home_wrap", {58'd0, sx5, sy5}, 64'd0);
      cx[0] = 0; cy[0] = 0;

      // ---------------- blinker 5x5 wrap ----------------
      wrap[0] = 1'b1;
      set_cell(0, 1, 2); set_cell(0, 2, 2); set_cell(0, 3, 2);
      chk("blk_load", f_grid(0), 64'h3800);
      chk("sel_alive", {63'd0, alive5}, 64'd1);
      gen_step(0, 0, 1'b0, bc, dn);
      chk("blk_busy_cycles", bc, 6);
      chk("blk_done_at", dn, 6);
      chk("blk_grid", f_grid(0), 64'h21080);
      chk("blk_gen", {48'd0, gen5}, 64'd1);
      chk("blk_st_ex", {62'd0, st5, ex5}, 64'd0);

      clear_grid(0);
      chk("clr_grid", f_grid(0), 64'd0);
      chk("clr_gen", {48'd0, gen5}, 64'd0);

      // ---------------- edge modes ----------------
      wrap[0] = 1'b0;
      set_cell(0, 0, 1); set_cell(0, 0, 2); set_cell(0, 0, 3);
      gen_step(0, 0, 1'b0, bc, dn);
      chk("edge_dead", f_grid(0), 64'hC00);
      clear_grid(0);
      wrap[0] = 1'b1;
      set_cell(0, 0, 1); set_cell(0, 0, 2); set_cell(0, 0, 3);
      gen_step(0, 0, 1'b1, bc, dn);   // wrap_i drops right after start
      chk("edge_wrap_latched", f_grid(0), 64'h4C00);
      clear_grid(0);

      // ---------------- still life, toggle while busy ----------------
      wrap[0] = 1'b0;
      set_cell(0, 1, 1); set_cell(0, 2, 1); set_cell(0, 1, 2); set_cell(0, 2, 2);
      gen_step(0, 2, 1'b0, bc, dn);
      chk("block_grid", f_grid(0), 64'h18C0);
      chk("block_stable", {62'd0, st5, ex5}, 64'b10);
      chk("block_gen", {48'd0, gen5}, 64'd1);

      // ---------------- lone cell dies ----------------
      set_cell(0, 1, 1); set_cell(0, 2, 1); set_cell(0, 1, 2);
      chk("lone_load", f_grid(0), 64'h1000);
      gen_step(0, 0, 1'b0, bc, dn);
      chk("lone_grid", f_grid(0), 64'd0);
      chk("lone_st_ex", {62'd0, st5, ex5}, 64'b01);
      chk("lone_gen", {48'd0, gen5}, 64'd2);

      // ---------------- clear and step together ----------------
      set_cell(0, 0, 0);
      chk("cs_load", f_grid(0), 64'h1);
      clr[0] = 1'b1; step[0] = 1'b1; cyc(); clr[0] = 1'b0; step[0] = 1'b0;
      chk("cs_grid", f_grid(0), 64'd0);
      chk("cs_gen_busy", {47'd0, gen5, busy5}, 64'd0);
      cyc(); cyc();
      chk("cs_busy_later", {63'd0, busy5}, 64'd0);

      // ---------------- clear aborts a generation ----------------
      set_cell(0, 2, 2); set_cell(0, 3, 2); set_cell(0, 4, 2);
      g0 = gd_cnt[0];
      step[0] = 1'b1; cyc(); step[0] = 1'b0;
      cyc();
      chk("abort_was_busy", {63'd0, busy5}, 64'd1);
      clr[0] = 1'b1; cyc(); clr[0] = 1'b0;
      chk("abort_busy", {63'd0, busy5}, 64'd0);
      chk("abort_grid", f_grid(0), 64'd0);
      repeat (8) cyc();
      chk("abort_no_done", gd_cnt[0] - g0, 0);
      chk("abort_gen", {48'd0, gen5}, 64'd0);

      // ---------------- glider 8x8 run mode ----------------
      wrap[1] = 1'b1;
      set_cell(1, 1, 0); set_cell(1, 2, 1); set_cell(1, 0, 2);
      set_cell(1, 1, 2); set_cell(1, 2, 2);
      chk("gl_load", f_grid(1), 64'h70402);
      tick[1] = 1'b1; cyc(); tick[1] = 1'b0;
      chk("tick_ignored_paused", {63'd0, busy8}, 64'd0);
      run_t[1] = 1'b1; cyc(); run_t[1] = 1'b0;
      chk("gl_running", {63'd0, run8}, 64'd1);
      step[1] = 1'b1; cyc(); step[1] = 1'b0;
      chk("step_ignored_run", {63'd0, busy8}, 64'd0);
      g0 = gd_cnt[1];
      for (int i = 0; i < 32; i++) begin
         tick[1] = 1'b1; cyc(); tick[1] = 1'b0;
         repeat (19) cyc();
      end
      repeat (5) cyc();
      chk("gl_done_pulses", gd_cnt[1] - g0, 32);
      chk("gl_grid", f_grid(1), 64'h70402);
      chk("gl_gen", {48'd0, gen8}, 64'd32);
      chk("gl_extinct", {63'd0, ex8}, 64'd0);
      run_t[1] = 1'b1; cyc(); run_t[1] = 1'b0;
      chk("gl_stopped", {63'd0, run8}, 64'd0);

      // ---------------- async reset mid-evolve ----------------
      step[1] = 1'b1; cyc(); step[1] = 1'b0;
      cyc(); cyc(); cyc();             // row 3 now in progress
      chk("pre_rst_busy", {63'd0, busy8}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_grid", f_grid(1), 64'd0);
      chk("arst_gen", {48'd0, gen8}, 64'd0);
      chk("arst_sel", {58'd0, sx8, sy8}, 64'd0);
      chk("arst_flags", {58'd0, alive8, run8, busy8, gd8, st8, ex8}, 64'd0);
      cx[0] = 0; cy[0] = 0; cx[1] = 0; cy[1] = 0;
      cyc();
      rst_n = 1'b1;
      cyc();
      chk("post_rst_idle", {63'd0, busy8}, 64'd0);
      gen_step(1, 0, 1'b0, bc, dn);
      chk("empty_busy_cycles", bc, 9);
      chk("empty_done_at", dn, 9);
      chk("empty_st_ex", {62'd0, st8, ex8}, 64'b11);
      chk("empty_gen", {48'd0, gen8}, 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
